// File: rtl/pio_pkg.sv
// Shared types and constants for the side-set / delay block.
package pio_pkg;

  localparam int unsigned DELAY_W   = 5;
  localparam int unsigned SS_W      = 5;
  localparam int unsigned SS_BITS_W = 3;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STALLED = 2'd1,
    ST_DELAY   = 2'd2
  } state_t;

  // One side-set write: data value plus per-bit write enable.
  typedef struct packed {
    logic [SS_W-1:0] data;
    logic [SS_W-1:0] mask;
  } ss_pair_t;

  // Low-order mask of 'bits' ones; counts above SS_W saturate to all ones.
  function automatic logic [SS_W-1:0] ss_mask(input logic [SS_BITS_W-1:0] bits);
    logic [SS_W-1:0] m;
    m = '0;
    for (int unsigned i = 0; i < SS_W; i++) begin
      m[i] = (i < 32'(bits));
    end
    return m;
  endfunction

endpackage

// File: rtl/pio_delay_counter.sv
// Loadable down-counter for instruction delay cycles; stops at zero.
module pio_delay_counter
  import pio_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic               clear,
  input  logic               load,
  input  logic               en,
  input  logic [DELAY_W-1:0] load_value,
  output logic               done
);

  logic [DELAY_W-1:0] count;

  // Clear wins over load, load wins over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (en && (count != '0)) begin
      count <= count - DELAY_W'(1);
    end
  end

  // Last delay tick is the one taken while the count reads 1.
  assign done = (count == DELAY_W'(1));

endmodule

// File: rtl/delay_sideset.sv
// Side-set application and post-instruction delay sequencing.
// Optional feature: define PIO_SIDESET_PINDIR_EN to let side-set target
// pin directions (ss_dirs / ss_dirs_mask) when sideset_pindir is set.
module delay_sideset
  import pio_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 en,
  input  logic                 issue,
  input  logic                 stall,
  input  logic                 restart,
  input  logic [DELAY_W-1:0]   delay,
  input  logic [SS_W-1:0]      side_set,
  input  logic                 sideset_enabled,
  input  logic [SS_BITS_W-1:0] sideset_bits,
  input  logic                 sideset_pindir,
  output logic [SS_W-1:0]      ss_pins,
  output logic [SS_W-1:0]      ss_pins_mask,
  output logic [SS_W-1:0]      ss_dirs,
  output logic [SS_W-1:0]      ss_dirs_mask,
  output logic                 busy
);

  state_t   state;
  state_t   state_next;
  logic     cnt_done;
  logic     complete_c;
  logic     fire_c;
  logic     dec_c;
  ss_pair_t ss_new;

  // State register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state: restart dominates; otherwise advance only on en ticks.
  always_comb begin
    state_next = state;
    if (restart) begin
      state_next = ST_IDLE;
    end else if (en) begin
      case (state)
        ST_IDLE, ST_STALLED: begin
          if (issue && stall) begin
            state_next = ST_STALLED;
          end else if (issue && (delay != '0)) begin
            state_next = ST_DELAY;
          end else begin
            state_next = ST_IDLE;
          end
        end
        ST_DELAY: begin
          if (cnt_done) begin
            state_next = ST_IDLE;
          end
        end
        default: state_next = ST_IDLE;
      endcase
    end
  end

  // Output decode: busy from state, plus strobes for counter and side-set.
  always_comb begin
    busy       = (state == ST_DELAY);
    complete_c = 1'b0;
    fire_c     = 1'b0;
    dec_c      = 1'b0;
    if (!restart && en) begin
      complete_c = issue && !stall && (state != ST_DELAY);
      fire_c     = issue && (state == ST_IDLE) && sideset_enabled &&
                   (sideset_bits != '0);
      dec_c      = (state == ST_DELAY);
    end
  end

  // Masked side-set payload for the current instruction.
  always_comb begin
    ss_new.mask = ss_mask(sideset_bits);
    ss_new.data = side_set & ss_new.mask;
  end

  pio_delay_counter u_delay_counter (
    .clk        (clk),
    .reset_n    (reset_n),
    .clear      (restart),
    .load       (complete_c),
    .en         (dec_c),
    .load_value (delay),
    .done       (cnt_done)
  );

`ifdef PIO_SIDESET_PINDIR_EN
  // Side-set registers: masks pulse for one en tick, data holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_pins      <= '0;
      ss_pins_mask <= '0;
      ss_dirs      <= '0;
      ss_dirs_mask <= '0;
    end else if (restart) begin
      ss_pins_mask <= '0;
      ss_dirs_mask <= '0;
    end else if (en) begin
      ss_pins_mask <= '0;
      ss_dirs_mask <= '0;
      if (fire_c) begin
        if (sideset_pindir) begin
          ss_dirs      <= ss_new.data;
          ss_dirs_mask <= ss_new.mask;
        end else begin
          ss_pins      <= ss_new.data;
          ss_pins_mask <= ss_new.mask;
        end
      end
    end
  end
`else
  logic unused_pindir;

  // Side-set registers: masks pulse for one en tick, data holds.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ss_pins      <= '0;
      ss_pins_mask <= '0;
    end else if (restart) begin
      ss_pins_mask <= '0;
    end else if (en) begin
      ss_pins_mask <= '0;
      if (fire_c) begin
        ss_pins      <= ss_new.data;
        ss_pins_mask <= ss_new.mask;
      end
    end
  end

  assign ss_dirs       = '0;
  assign ss_dirs_mask  = '0;
  assign unused_pindir = sideset_pindir;
`endif

endmodule

// File: tb/tb_delay_sideset.sv
// Scoreboard bench for delay_sideset: the driver queues hand-computed
// expected outputs after each clock edge, a monitor compares on negedge.
module tb_delay_sideset;

`ifdef PIO_SIDESET_PINDIR_EN
  localparam int PD = 1;
`else
  localparam int PD = 0;
`endif

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       en = 1'b0;
  logic       issue = 1'b0;
  logic       stall = 1'b0;
  logic       restart = 1'b0;
  logic [4:0] delay = '0;
  logic [4:0] side_set = '0;
  logic       sideset_enabled = 1'b0;
  logic [2:0] sideset_bits = '0;
  logic       sideset_pindir = 1'b0;
  logic [4:0] ss_pins;
  logic [4:0] ss_pins_mask;
  logic [4:0] ss_dirs;
  logic [4:0] ss_dirs_mask;
  logic       busy;

  typedef struct {
    logic [20:0] vec;
    string       name;
  } exp_t;

  exp_t        sb[$];
  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  always #5 clk = ~clk;

  delay_sideset dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .en              (en),
    .issue           (issue),
    .stall           (stall),
    .restart         (restart),
    .delay           (delay),
    .side_set        (side_set),
    .sideset_enabled (sideset_enabled),
    .sideset_bits    (sideset_bits),
    .sideset_pindir  (sideset_pindir),
    .ss_pins         (ss_pins),
    .ss_pins_mask    (ss_pins_mask),
    .ss_dirs         (ss_dirs),
    .ss_dirs_mask    (ss_dirs_mask),
    .busy            (busy)
  );

  function automatic logic [20:0] pack_exp(input int p, input int pm, input int d,
                                           input int dm, input int b);
    return {5'(p), 5'(pm), 5'(d), 5'(dm), 1'(b)};
  endfunction

  task automatic push_exp(input logic [20:0] v, input string name);
    exp_t e;
    e.vec  = v;
    e.name = name;
    sb.push_back(e);
  endtask

  // Drive one tick of inputs, clock it, queue the expected post-edge outputs.
  task automatic step(input int e, input int iss, input int stl, input int rst,
                      input int dly, input int ss, input int sse, input int bits,
                      input int pdir, input int xp, input int xpm, input int xd,
                      input int xdm, input int xb, input string name);
    en              = 1'(e);
    issue           = 1'(iss);
    stall           = 1'(stl);
    restart         = 1'(rst);
    delay           = 5'(dly);
    side_set        = 5'(ss);
    sideset_enabled = 1'(sse);
    sideset_bits    = 3'(bits);
    sideset_pindir  = 1'(pdir);
    @(posedge clk);
    push_exp(pack_exp(xp, xpm, xd, xdm, xb), name);
    @(negedge clk);
  endtask

  // Monitor: compare every queued expectation against the settled outputs.
  initial begin
    exp_t        e;
    logic [20:0] got;
    forever begin
      @(negedge clk);
      while (sb.size() != 0) begin
        e   = sb.pop_front();
        got = {ss_pins, ss_pins_mask, ss_dirs, ss_dirs_mask, busy};
        n_vec++;
        if (got !== e.vec) begin
          n_bad++;
          $display("FAIL %s: got pins=%b pmask=%b dirs=%b dmask=%b busy=%b, want pins=%b pmask=%b dirs=%b dmask=%b busy=%b",
                   e.name, got[20:16], got[15:11], got[10:6], got[5:1], got[0],
                   e.vec[20:16], e.vec[15:11], e.vec[10:6], e.vec[5:1], e.vec[0]);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got running, want finished");
    $fatal(1, "watchdog");
  end

  initial begin
    @(negedge clk);
    // Reset held: issue is ignored and everything stays zero.
    step(1,1,0,0,3,3,1,2,0, 0,0,0,0,0, "reset_hold");
    step(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, "reset_hold2");
    reset_n = 1'b1;
    step(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, "release");

    // bits=2, side_set=00011, delay=3, no stall; en low tick holds the mask.
    step(1,1,0,0,3,5'b00011,1,2,0, 3,3,0,0,1, "t1_issue");
    step(0,0,0,0,0,0,0,0,0,        3,3,0,0,1, "t1_en_low_hold");
    step(1,0,0,0,0,0,0,0,0,        3,0,0,0,1, "t1_d2");
    step(1,0,0,0,0,0,0,0,0,        3,0,0,0,1, "t1_d3");
    step(1,0,0,0,0,0,0,0,0,        3,0,0,0,0, "t1_done");

    // Stalled 4 ticks then complete with delay=2; mask pulses only once.
    step(1,1,1,0,2,5'b10101,1,3,0, 5'b00101,5'b00111,0,0,0, "t2_stall1");
    step(1,1,1,0,2,5'b10101,1,3,0, 5'b00101,0,0,0,0,        "t2_stall2");
    step(1,1,1,0,2,5'b10101,1,3,0, 5'b00101,0,0,0,0,        "t2_stall3");
    step(1,1,1,0,2,5'b10101,1,3,0, 5'b00101,0,0,0,0,        "t2_stall4");
    step(1,1,0,0,2,5'b10101,1,3,0, 5'b00101,0,0,0,1,        "t2_complete");
    step(1,0,0,0,0,0,0,0,0,        5'b00101,0,0,0,1,        "t2_d2");
    step(1,0,0,0,0,0,0,0,0,        5'b00101,0,0,0,0,        "t2_done");

    // en toggling with delay=4: busy spans 4 en-high ticks; issue while busy ignored.
    step(0,1,0,0,4,5'b00001,1,1,0, 5,0,0,0,0, "t3_en_low_issue");
    step(1,1,0,0,4,0,0,0,0,        5,0,0,0,1, "t3_issue");
    step(0,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_lo1");
    step(1,1,0,0,7,5'b11111,1,5,0, 5,0,0,0,1, "t3_busy_issue");
    step(0,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_lo2");
    step(1,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_hi2");
    step(0,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_lo3");
    step(1,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_hi3");
    step(0,0,0,0,0,0,0,0,0,        5,0,0,0,1, "t3_lo4");
    step(1,0,0,0,0,0,0,0,0,        5,0,0,0,0, "t3_hi4_done");

    // delay=31, restart on the second DELAY tick; restart beats a side-set.
    step(1,1,0,0,31,5'b11110,1,1,0, 0,1,0,0,1, "t4_issue");
    step(1,0,0,0,0,0,0,0,0,         0,0,0,0,1, "t4_d1");
    step(1,0,0,1,0,0,0,0,0,         0,0,0,0,0, "t4_restart");
    step(1,0,0,0,0,0,0,0,0,         0,0,0,0,0, "t4_after");
    step(1,1,0,1,0,5'b00011,1,2,0,  0,0,0,0,0, "t4_restart_prio");
    step(1,1,0,0,0,5'b00011,1,2,0,  3,3,0,0,0, "t4_pulse");
    step(0,0,0,1,0,0,0,0,0,         3,0,0,0,0, "t4_restart_en_low");

    // No side-set when disabled or zero bits; delay=0 never raises busy.
    step(1,1,0,0,0,5'b00011,0,2,0, 3,0,0,0,0, "t5_ss_off");
    step(1,1,0,0,0,5'b01100,1,0,0, 3,0,0,0,0, "t5_bits0");
    step(1,0,0,0,0,0,0,0,0,        3,0,0,0,0, "t5_idle");

    // pindir routing (depends on build), then async reset mid-DELAY.
    step(1,1,0,0,3,5'b00001,1,1,1, (PD != 0) ? 3 : 1, (PD != 0) ? 0 : 1,
         (PD != 0) ? 1 : 0, (PD != 0) ? 1 : 0, 1, "t6_issue");
    step(1,0,0,0,0,0,0,0,0, (PD != 0) ? 3 : 1, 0, (PD != 0) ? 1 : 0, 0, 1, "t6_d1");
    en    = 1'b1;
    issue = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b0;
    push_exp(pack_exp(0,0,0,0,0), "t6_async_reset");
    @(negedge clk);
    step(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, "t6_reset_hold");
    reset_n = 1'b1;
    step(1,0,0,0,0,0,0,0,0, 0,0,0,0,0, "t6_release");

    @(negedge clk);
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/delay_sideset.md
DELAY_SIDESET -- requirements
Module: delay_sideset

Interface
REQ-001 SHALL have ports: clk  in  1  state-machine clock, rising edge.
REQ-002 SHALL have ports: reset_n  in  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: en  in  1  clock-divider tick; state advances only when high.
REQ-004 SHALL have ports: issue  in  1  decoded instruction executes this tick.
REQ-005 SHALL have ports: stall  in  1  issued instruction blocked (wait/push/pull not satisfied).
REQ-006 SHALL have ports: restart  in  1  synchronous state-machine restart.
REQ-007 SHALL have ports: delay  in  5  delay field from decoder.
REQ-008 SHALL have ports: side_set  in  5  side-set field from decoder; the enable bit, if present, is the MSB.
REQ-009 SHALL have ports: sideset_enabled  in  1  side-set applies to this instruction.
REQ-010 SHALL have ports: sideset_bits  in  3  side-set data bit count, 0..5, excluding the enable bit.
REQ-011 SHALL have ports: sideset_pindir  in  1  config: side-set targets pin directions.
REQ-012 SHALL have ports: ss_pins, ss_pins_mask, ss_dirs, ss_dirs_mask  out  5 each  registered side-set values and write masks.
REQ-013 SHALL have ports: busy  out  1  delay in progress; fetch and PC advance blocked.

Function
REQ-014 SHALL implement states IDLE, STALLED and DELAY.
REQ-015 SHALL ignore all inputs except restart when en=0; outputs hold.
REQ-016 SHALL form data = side_set & ((1<<sideset_bits)-1) and mask = (1<<sideset_bits)-1 when en & issue & sideset_enabled & (sideset_bits != 0).
REQ-017 SHALL register the data/mask pair of REQ-016 onto ss_pins/ss_pins_mask (or ss_dirs/ss_dirs_mask, per REQ-030) on the first issuing tick, including when stall=1; the other output pair's mask is 0.
REQ-018 SHALL make every mask output a one-tick pulse: it clears to 0 on the next en tick unless a new side-set occurs; data outputs hold their last value.
REQ-019 SHALL apply side-set once per instruction; re-issue while in STALLED does not re-pulse the masks.
REQ-020 SHALL transition IDLE -> STALLED on issue & stall, and hold STALLED while issue & stall.
REQ-021 SHALL start the delay on the tick the instruction completes (issue & !stall): if delay > 0, load the counter with delay and enter DELAY; else go to IDLE.
REQ-022 SHALL decrement the counter in DELAY on each en tick, return to IDLE when it reaches 1, and never wrap below 0.
REQ-023 SHALL assert busy combinationally in DELAY only, so delay=N blocks exactly N en ticks after the completing tick; delay=31 gives 31 ticks.
REQ-024 SHALL ignore issue while busy=1 (protocol violation; no side-set, no reload).
REQ-025 SHALL, on restart (priority over everything, en-independent), clear the counter and all masks and enter IDLE; data outputs hold.

Reset
REQ-026 SHALL, on reset_n low, asynchronously force: state IDLE, counter 0, busy 0, all four outputs 0.
REQ-027 SHALL release reset synchronously to clk, with no activity on the first edge unless issue & en.

Configuration
REQ-028 SHALL compile the pindir side-set feature in or out with macro PIO_SIDESET_PINDIR_EN.
REQ-029 SHALL, without PIO_SIDESET_PINDIR_EN, ignore sideset_pindir and tie ss_dirs and ss_dirs_mask to 0.
REQ-030 SHALL, with PIO_SIDESET_PINDIR_EN defined, route the side-set to ss_dirs/ss_dirs_mask when sideset_pindir=1, and to ss_pins/ss_pins_mask otherwise.

Structure
REQ-031 SHALL take the state enum, DELAY_W=5 and SS_W=5 from shared package pio_pkg.
REQ-032 SHALL instantiate exactly one sub-module, pio_delay_counter: a loadable 5-bit down-counter with en and clear inputs and a done output.

Verification
REQ-033 SHALL cover: sideset_bits=2, side_set=5'b00011, delay=3, issue, no stall -> ss_pins_mask=00011 for one tick, busy high for exactly 3 en ticks.
REQ-034 SHALL cover: issue with stall=1 for 4 ticks, then stall=0, delay=2 -> mask pulses once on the first tick, busy rises after the completing tick and lasts 2 ticks.
REQ-035 SHALL cover: en toggling 1/0 with delay=4 -> busy lasts exactly 4 en-high ticks, independent of clk count.
REQ-036 SHALL cover: restart on the second DELAY tick with delay=31 -> busy=0 and masks 0 on the next edge.
REQ-037 SHALL cover: sideset_enabled=0 or sideset_bits=0 with delay=0 -> no mask pulse, busy never asserted.
REQ-038 SHALL cover: with PIO_SIDESET_PINDIR_EN, sideset_pindir=1, side_set=1 -> ss_dirs_mask=00001 pulse and ss_pins_mask stays 0; async reset_n low mid-DELAY -> all outputs 0 immediately.
